// File: rtl/ctrl_pkg.sv
// Shared constants for the ID-stage control unit: opcodes,
// control-word bit positions, FSM state encoding, decode bundle.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int CB_REG_WRITE  = 0;
   localparam int CB_MEM_READ   = 1;
   localparam int CB_MEM_WRITE  = 2;
   localparam int CB_ALU_SRC    = 3;
   localparam int CB_MEM_TO_REG = 4;
   localparam int CB_BRANCH     = 5;
   localparam int CB_JUMP       = 6;
   localparam int CB_ALU_OP_LO  = 7;
   localparam int CB_ALU_OP_HI  = 8;
   localparam int CB_PC_ALU     = 9;
   localparam int CB_ZERO_RS1   = 10;

   localparam int NB_BASE_CTRL = 11;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   typedef struct packed {
      logic [NB_BASE_CTRL-1:0] ctrl;
      logic                    known;
      logic                    use_rs1;
      logic                    use_rs2;
      logic                    is_system;
   } dec_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode decoder.
// in: i_opcode[6:0]; out: o_dec (control word, known, rs usage, system).
module ctrl_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output dec_t       o_dec
);

   always_comb begin
      o_dec = '0;
      unique case (i_opcode)
         OP_R: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_OP_HI] = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
            o_dec.use_rs2            = 1'b1;
         end
         OP_IMM: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.ctrl[CB_ALU_OP_HI] = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
         end
         OP_JALR: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.ctrl[CB_JUMP]      = 1'b1;
            o_dec.ctrl[CB_ALU_OP_HI] = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
         end
         OP_SYSTEM: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
            o_dec.is_system          = 1'b1;
         end
         OP_LOAD: begin
            o_dec.ctrl[CB_REG_WRITE]  = 1'b1;
            o_dec.ctrl[CB_MEM_READ]   = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]    = 1'b1;
            o_dec.ctrl[CB_MEM_TO_REG] = 1'b1;
            o_dec.known               = 1'b1;
            o_dec.use_rs1             = 1'b1;
         end
         OP_STORE: begin
            o_dec.ctrl[CB_MEM_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
            o_dec.use_rs2            = 1'b1;
         end
         OP_BRANCH: begin
            o_dec.ctrl[CB_BRANCH]    = 1'b1;
            o_dec.ctrl[CB_ALU_OP_LO] = 1'b1;
            o_dec.known              = 1'b1;
            o_dec.use_rs1            = 1'b1;
            o_dec.use_rs2            = 1'b1;
         end
         OP_LUI: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.ctrl[CB_ZERO_RS1]  = 1'b1;
            o_dec.known              = 1'b1;
         end
         OP_AUIPC: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_ALU_SRC]   = 1'b1;
            o_dec.ctrl[CB_PC_ALU]    = 1'b1;
            o_dec.known              = 1'b1;
         end
         OP_JAL: begin
            o_dec.ctrl[CB_REG_WRITE] = 1'b1;
            o_dec.ctrl[CB_JUMP]      = 1'b1;
            o_dec.ctrl[CB_PC_ALU]    = 1'b1;
            o_dec.known              = 1'b1;
         end
         default: o_dec = '0;
      endcase
   end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// ID-stage control unit: decode, load-use stall, SYSTEM drain FSM,
// registered ID/EX control word.
// Ports: i_clk, i_rst_n, i_valid, i_instr, i_flush -> o_ctrl, o_valid,
// o_rd, o_stall (comb), o_illegal (sticky).
// Option: CTRL_ILLEGAL_TRAP_EN turns unknown opcodes into bubbles
// and sets o_illegal; otherwise they pass with a zero control word.
module pipelined_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int NB_CTRL  = 11,
   parameter int NB_INSTR = 32,
   parameter int NB_REG   = 5,
   parameter int N_DRAIN  = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   input  logic [NB_INSTR-1:0] i_instr,
   input  logic                i_flush,
   output logic [NB_CTRL-1:0]  o_ctrl,
   output logic                o_valid,
   output logic [NB_REG-1:0]   o_rd,
   output logic                o_stall,
   output logic                o_illegal
);

   localparam logic [3:0] DRAIN_INIT = 4'(N_DRAIN);

   dec_t dec;

   logic [NB_CTRL-1:0] ctrl_q, ctrl_d;
   logic               valid_q, valid_d;
   logic [NB_REG-1:0]  rd_q, rd_d;
   logic [0:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;

   logic [NB_REG-1:0] rs1;
   logic [NB_REG-1:0] rs2;
   logic [NB_REG-1:0] rd;
   logic              load_use;
   logic              accept;
   logic              issue;

   ctrl_decoder u_dec (
      .i_opcode (i_instr[6:0]),
      .o_dec    (dec)
   );

   assign rs1 = i_instr[15 +: NB_REG];
   assign rs2 = i_instr[20 +: NB_REG];
   assign rd  = i_instr[7 +: NB_REG];

   // Only a load sitting in ID/EX can create a hazard; x0 never does.
   always_comb begin
      load_use = 1'b0;
      if (valid_q && ctrl_q[CB_MEM_READ] && rd_q != '0 && i_valid) begin
         load_use = (dec.use_rs1 && rs1 == rd_q) ||
                    (dec.use_rs2 && rs2 == rd_q);
      end
   end

   // Flush wins over any stall source.
   assign o_stall = !i_flush && (state_q == ST_DRAIN || load_use);
   assign accept  = i_valid && !o_stall && !i_flush;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   assign issue     = accept && dec.known;
   assign illegal_d = illegal_q || (accept && !dec.known);
   assign o_illegal = illegal_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) illegal_q <= 1'b0;
      else          illegal_q <= illegal_d;
   end
`else
   assign issue     = accept;
   assign o_illegal = 1'b0;
`endif

   always_comb begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      rd_d    = '0;
      if (issue) begin
         ctrl_d  = NB_CTRL'(dec.ctrl);
         valid_d = 1'b1;
         rd_d    = rd;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (i_flush) begin
         state_d = ST_RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept && dec.is_system) begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_INIT;
               end
            end
            ST_DRAIN: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         rd_q    <= '0;
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_ctrl  = ctrl_q;
   assign o_valid = valid_q;
   assign o_rd    = rd_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Scoreboard bench for pipelined_ctrl_unit: stimulus pushes expected
// {ctrl,rd}; a monitor pops and compares on every o_valid.
module tb_pipelined_ctrl_unit;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_instr;
   logic        i_flush;
   logic [10:0] o_ctrl;
   logic        o_valid;
   logic [4:0]  o_rd;
   logic        o_stall;
   logic        o_illegal;

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] exp_q[$];

   pipelined_ctrl_unit #(
      .NB_CTRL  (11),
      .NB_INSTR (32),
      .NB_REG   (5),
      .N_DRAIN  (3)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (i_valid),
      .i_instr   (i_instr),
      .i_flush   (i_flush),
      .o_ctrl    (o_ctrl),
      .o_valid   (o_valid),
      .o_rd      (o_rd),
      .o_stall   (o_stall),
      .o_illegal (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Monitor: every valid output must match the oldest expectation.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out: got ctrl %0h rd %0d want none",
                        o_ctrl, o_rd);
            end else begin
               e = exp_q.pop_front();
               chk("ctrl", {21'd0, o_ctrl}, {21'd0, e[15:5]});
               chk("rd", {27'd0, o_rd}, {27'd0, e[4:0]});
            end
         end
      end
   end

   // One cycle: drive, check stall mid-cycle, push expectation.
   task automatic cyc(input logic v, input logic [31:0] ins,
                      input logic fl, input logic es, input logic push,
                      input logic [10:0] ec, input logic [4:0] er);
      i_valid = v;
      i_instr = ins;
      i_flush = fl;
      @(negedge clk);
      chk("stall", {31'd0, o_stall}, {31'd0, es});
      if (push) exp_q.push_back({ec, er});
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] ADD3  = 32'h002081B3;
   localparam logic [31:0] LW5   = 32'h0000A283;
   localparam logic [31:0] ADD6  = 32'h00028333;
   localparam logic [31:0] LW0   = 32'h0000A003;
   localparam logic [31:0] ADD60 = 32'h00000333;
   localparam logic [31:0] SW5   = 32'h00512023;
   localparam logic [31:0] ECALL = 32'h00000073;
   localparam logic [31:0] ILL   = 32'h0000007F;

   logic [31:0] tbl_ins [6];
   logic [10:0] tbl_ctl [6];
   logic [4:0]  tbl_rd  [6];

   initial begin
      tbl_ins[0] = 32'h00100093; tbl_ctl[0] = 11'h109; tbl_rd[0] = 5'd1;
      tbl_ins[1] = 32'h000080E7; tbl_ctl[1] = 11'h149; tbl_rd[1] = 5'd1;
      tbl_ins[2] = 32'h00000063; tbl_ctl[2] = 11'h0A0; tbl_rd[2] = 5'd0;
      tbl_ins[3] = 32'h000012B7; tbl_ctl[3] = 11'h409; tbl_rd[3] = 5'd5;
      tbl_ins[4] = 32'h00001297; tbl_ctl[4] = 11'h209; tbl_rd[4] = 5'd5;
      tbl_ins[5] = 32'h000000EF; tbl_ctl[5] = 11'h241; tbl_rd[5] = 5'd1;

      rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_flush = 1'b0;
      #3;
      chk("rst_ctrl", {21'd0, o_ctrl}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic add, then load-use with rs1
      cyc(1, ADD3, 0, 0, 1, 11'h101, 5'd3);
      cyc(1, LW5,  0, 0, 1, 11'h01B, 5'd5);
      cyc(1, ADD6, 0, 1, 0, 11'h0,   5'd0);
      cyc(1, ADD6, 0, 0, 1, 11'h101, 5'd6);

      // flush in the stall cycle
      cyc(1, LW5,  0, 0, 1, 11'h01B, 5'd5);
      cyc(1, ADD6, 1, 0, 0, 11'h0,   5'd0);
      chk("flush_bubble", {31'd0, o_valid}, 32'd0);
      cyc(0, '0,   0, 0, 0, 11'h0,   5'd0);

      // x0 destination never stalls
      cyc(1, LW0,   0, 0, 1, 11'h01B, 5'd0);
      cyc(1, ADD60, 0, 0, 1, 11'h101, 5'd6);

      // rs2 hazard through a store
      cyc(1, LW5, 0, 0, 1, 11'h01B, 5'd5);
      cyc(1, SW5, 0, 1, 0, 11'h0,   5'd0);
      cyc(1, SW5, 0, 0, 1, 11'h00C, 5'd0);

      // ecall drains exactly three cycles
      cyc(1, ECALL, 0, 0, 1, 11'h009, 5'd0);
      cyc(1, ADD3,  0, 1, 0, 11'h0,   5'd0);
      cyc(1, ADD3,  0, 1, 0, 11'h0,   5'd0);
      cyc(1, ADD3,  0, 1, 0, 11'h0,   5'd0);
      cyc(1, ADD3,  0, 0, 1, 11'h101, 5'd3);

      // flush aborts drain
      cyc(1, ECALL, 0, 0, 1, 11'h009, 5'd0);
      cyc(1, ADD3,  1, 0, 0, 11'h0,   5'd0);
      cyc(1, ADD3,  0, 0, 1, 11'h101, 5'd3);

      // remaining opcodes
      cyc(0, '0, 0, 0, 0, 11'h0, 5'd0);
      for (int i = 0; i < 6; i++)
         cyc(1, tbl_ins[i], 0, 0, 1, tbl_ctl[i], tbl_rd[i]);

      // reset in the middle of drain
      cyc(1, ECALL, 0, 0, 1, 11'h009, 5'd0);
      i_valid = 1'b0;
      @(negedge clk);
      chk("drain_stall", {31'd0, o_stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, o_stall}, 32'd0);
      chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("mid_rst_ctrl", {21'd0, o_ctrl}, 32'd0);
      chk("mid_rst_rd", {27'd0, o_rd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i_valid = 1'b1; i_instr = ADD3; i_flush = 1'b0;
      #1;
      chk("post_rst_stall", {31'd0, o_stall}, 32'd0);
      exp_q.push_back({11'h101, 5'd3});
      @(posedge clk); #1;

      // unknown opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
      cyc(1, ILL, 0, 0, 0, 11'h0, 5'd0);
      chk("ill_valid", {31'd0, o_valid}, 32'd0);
      chk("ill_flag", {31'd0, o_illegal}, 32'd1);
      cyc(1, ADD3, 0, 0, 1, 11'h101, 5'd3);
      cyc(0, '0, 0, 0, 0, 11'h0, 5'd0);
      chk("ill_sticky", {31'd0, o_illegal}, 32'd1);
`else
      cyc(1, ILL, 0, 0, 1, 11'h000, 5'd0);
      chk("ill_valid", {31'd0, o_valid}, 32'd1);
      chk("ill_flag", {31'd0, o_illegal}, 32'd0);
      cyc(0, '0, 0, 0, 0, 11'h0, 5'd0);
`endif

      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
